memory_interface: RTL and testbench
===================================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have: en_mem  input  1  core request strobe, sampled only in IDLE.
REQ-004 SHALL have: W_R_mem  input  2  request type: 00 data write, 01 data read, 11 instruction fetch, 10 treated as data read.
REQ-005 SHALL have: wordsize_mem  input  2  access size: 00 byte, 01 half, 10/11 word; ignored for fetch, which is always word.
REQ-006 SHALL have: sign_mem  input  1  1 = sign-extend read data, 0 = zero-extend.
REQ-007 SHALL have: addr  input  32  byte address of the access.
REQ-008 SHALL have: wdata  input  32  store data, right-aligned.
REQ-009 SHALL have: rdata  output  32  extended load data, valid from the done_mem cycle until the next load completes.
REQ-010 SHALL have: inst  output  32  fetched instruction, valid from the done_mem cycle until the next fetch completes.
REQ-011 SHALL have: busy_mem  output  1  bus transaction in progress.
REQ-012 SHALL have: done_mem  output  1  one-cycle completion pulse.
REQ-013 SHALL have: aligned_mem  output  1  0 = misaligned request seen (sticky).
REQ-014 SHALL have: mem_valid  output  1, mem_ready  input  1, mem_instr  output  1, mem_addr  output  32 (bits [1:0] = 0), mem_wstrb  output  4 (0 = read), mem_wdata  output  32, mem_rdata  input  32: external valid/ready bus.

Function
REQ-015 SHALL implement states IDLE, REQ, DONE, ERR.
REQ-016 IDLE: en_mem=1 with an aligned request SHALL register addr/type/size/sign/wdata and go to REQ next cycle; en_mem=0 SHALL stay IDLE.
REQ-017 Misaligned request (half with addr[0]=1; word or fetch with addr[1:0]!=0) SHALL go to ERR; no bus transaction, no done_mem pulse.
REQ-018 REQ: mem_valid=1, busy_mem=1; bus outputs held stable until mem_ready=1 is sampled, then next state DONE.
REQ-019 DONE: done_mem=1 and busy_mem=0 for exactly one cycle, then IDLE; an en_mem in DONE SHALL be ignored.
REQ-020 ERR: aligned_mem=0, busy_mem=0, mem_valid=0; remains until reset.
REQ-021 mem_addr SHALL be {addr[31:2],2'b00}; mem_instr=1 only for fetch.
REQ-022 Write strobes SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-023 mem_wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-024 Load data SHALL be mem_rdata lane selected by addr[1:0], extended to 32 bits per sign_mem, captured into rdata when mem_ready=1 in REQ.
REQ-025 Fetch SHALL capture mem_rdata into inst when mem_ready=1 in REQ; rdata SHALL be unchanged.
REQ-026 Write completion SHALL leave rdata and inst unchanged.
REQ-027 Latency: en_mem at cycle 0 -> mem_valid from cycle 1; mem_ready at cycle k -> done_mem at cycle k+1. Minimum is 2 cycles after the request.
REQ-028 mem_ready sampled outside REQ SHALL be ignored.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, including mid-transaction.
REQ-030 Reset SHALL clear mem_valid, busy_mem, done_mem, mem_wstrb, mem_instr, mem_addr, mem_wdata, rdata and inst to 0.
REQ-031 Reset SHALL set aligned_mem=1.

Verification
REQ-032 Fetch at addr 0x100 with mem_ready on the first REQ cycle and mem_rdata=0x00500093 -> mem_valid for 1 cycle, mem_instr=1, done_mem at request+2, inst=0x00500093.
REQ-033 Signed byte read at addr 0x203, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; the same read unsigned -> rdata=0x00000080.
REQ-034 Half write at addr 0x302, wdata=0x1234ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x300.
REQ-035 Word read at addr 0x401 -> aligned_mem=0 next cycle and sticky, mem_valid never asserted, done_mem never asserted.
REQ-036 Word read with mem_ready held low for 5 cycles -> mem_valid, mem_addr and busy_mem stable for 5 cycles; done_mem follows 1 cycle after mem_ready.
REQ-037 reset=0 asserted during REQ -> next cycle mem_valid=0, busy_mem=0, aligned_mem=1, and a new request is accepted normally after reset.

Source files
------------

// File: rtl/memory_interface.sv
// memory_interface: core load/store/fetch requests onto a valid/ready bus with lane steering and extension
module memory_interface (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_mem,
  input  logic [1:0]  W_R_mem,
  input  logic [1:0]  wordsize_mem,
  input  logic        sign_mem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] inst,
  output logic        busy_mem,
  output logic        done_mem,
  output logic        aligned_mem,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [1:0]  type_q, size_q;
  logic        sign_q;
  logic [31:0] addr_q, wdata_q, rdata_q, inst_q;
  logic        misaligned, accept, fetch, write, in_req;
  logic [31:0] lane, load_d;
  logic [3:0]  strobe;
  assign misaligned = (W_R_mem == 2'b11 || wordsize_mem[1]) ? |addr[1:0]
                    : (wordsize_mem == 2'b01) & addr[0];
  assign accept = state_q == IDLE && en_mem && !misaligned;
  assign fetch  = type_q == 2'b11;
  assign write  = type_q == 2'b00;
  assign in_req = state_q == REQ;
  always_ff @(posedge clk)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = en_mem ? (misaligned ? ERR : REQ) : IDLE;
      REQ:  state_d = mem_ready ? DONE : REQ;
      DONE: state_d = IDLE;
      ERR:  state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_valid   = in_req;
    busy_mem    = in_req;
    done_mem    = state_q == DONE;
    aligned_mem = state_q != ERR;
  end
  // Loads shift the addressed lane down to bit 0 before extension.
  assign lane   = mem_rdata >> {addr_q[1:0], 3'b000};
  assign load_d = size_q == 2'b00 ? {{24{sign_q & lane[7]}}, lane[7:0]}
                : size_q == 2'b01 ? {{16{sign_q & lane[15]}}, lane[15:0]}
                : mem_rdata;
  assign strobe = size_q == 2'b00 ? 4'b0001 << addr_q[1:0]
                : size_q == 2'b01 ? 4'b0011 << addr_q[1:0]
                : 4'b1111;
  always_ff @(posedge clk)
    if (!reset) begin
      type_q  <= 2'b00;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      inst_q  <= '0;
    end else begin
      if (accept) begin
        type_q  <= W_R_mem;
        size_q  <= W_R_mem == 2'b11 ? 2'b10 : wordsize_mem;
        sign_q  <= sign_mem;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (in_req && mem_ready && fetch) inst_q <= mem_rdata;
      if (in_req && mem_ready && !fetch && !write) rdata_q <= load_d;
    end
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_instr = in_req & fetch;
  assign mem_wstrb = (in_req && write) ? strobe : 4'b0000;
  assign mem_wdata = size_q == 2'b00 ? {4{wdata_q[7:0]}}
                   : size_q == 2'b01 ? {2{wdata_q[15:0]}}
                   : wdata_q;
  assign rdata = rdata_q;
  assign inst  = inst_q;
endmodule

// File: tb/tb_memory_interface.sv
// tb_memory_interface: directed and randomized transactions checked against a behavioural bus model
module tb_memory_interface;
  logic        clk = 0, reset = 0, en_mem = 0, sign_mem = 0, mem_ready = 0;
  logic [1:0]  W_R_mem = 0, wordsize_mem = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [31:0] rdata, inst, mem_addr, mem_wdata;
  logic        busy_mem, done_mem, aligned_mem, mem_valid, mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] exp_rdata = 0, exp_inst = 0;
  int checks = 0, errors = 0;

  memory_interface dut (
    .clk(clk), .reset(reset), .en_mem(en_mem), .W_R_mem(W_R_mem),
    .wordsize_mem(wordsize_mem), .sign_mem(sign_mem), .addr(addr), .wdata(wdata),
    .rdata(rdata), .inst(inst), .busy_mem(busy_mem), .done_mem(done_mem),
    .aligned_mem(aligned_mem), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [1:0] sz,
                                            input logic [31:0] a, input logic sg);
    int n;
    logic [31:0] v, mask;
    n = sz == 0 ? 8 : sz == 1 ? 16 : 32;
    if (n == 32) return rd;
    v = rd >> (8 * a[1:0]);
    mask = (32'h1 << n) - 1;
    v = v & mask;
    if (sg && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] strobe_of(input logic [1:0] sz, input logic [31:0] a);
    int bytes;
    bytes = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    return 4'(((1 << bytes) - 1) << (bytes == 4 ? 0 : a[1:0]));
  endfunction

  task automatic xact(input logic [1:0] t, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input int d);
    logic fetch, wr;
    logic [3:0] ws;
    logic [31:0] wpat;
    fetch = t == 2'b11;
    wr    = t == 2'b00;
    ws    = wr ? strobe_of(sz, a) : 4'b0000;
    wpat  = sz == 0 ? {4{wd[7:0]}} : sz == 1 ? {2{wd[15:0]}} : wd;
    @(negedge clk);
    en_mem = 1; W_R_mem = t; wordsize_mem = sz; sign_mem = sg; addr = a; wdata = wd;
    mem_ready = 0;
    @(negedge clk);
    en_mem = 0; addr = $urandom; wdata = $urandom;
    check("valid", 32'(mem_valid), 1);
    check("busy", 32'(busy_mem), 1);
    check("done_in_req", 32'(done_mem), 0);
    check("addr", mem_addr, a & ~32'h3);
    check("instr", 32'(mem_instr), 32'(fetch));
    check("wstrb", 32'(mem_wstrb), 32'(ws));
    if (wr) check("wdata", mem_wdata, wpat);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(mem_valid), 1);
      check("hold_busy", 32'(busy_mem), 1);
      check("hold_addr", mem_addr, a & ~32'h3);
      check("hold_wstrb", 32'(mem_wstrb), 32'(ws));
    end
    mem_ready = 1; mem_rdata = rd;
    @(negedge clk);
    if (fetch) exp_inst = rd;
    else if (!wr) exp_rdata = load_val(rd, sz, a, sg);
    check("done", 32'(done_mem), 1);
    check("busy_done", 32'(busy_mem), 0);
    check("valid_done", 32'(mem_valid), 0);
    check("rdata", rdata, exp_rdata);
    check("inst", inst, exp_inst);
    en_mem = 1; mem_rdata = $urandom;
    @(negedge clk);
    check("ignored_en", 32'(mem_valid), 0);
    check("done_once", 32'(done_mem), 0);
    check("rdata_hold", rdata, exp_rdata);
    check("inst_hold", inst, exp_inst);
    en_mem = 0; mem_ready = 0;
  endtask

  initial begin
    logic [1:0] t, sz;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(mem_valid), 0);
    check("rst_busy", 32'(busy_mem), 0);
    check("rst_done", 32'(done_mem), 0);
    check("rst_wstrb", 32'(mem_wstrb), 0);
    check("rst_instr", 32'(mem_instr), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_inst", inst, 0);
    check("rst_aligned", 32'(aligned_mem), 1);
    reset = 1;
    xact(2'b11, 2'b00, 0, 32'h100, 0, 32'h00500093, 0);
    check("fetch_inst", inst, 32'h00500093);
    xact(2'b01, 2'b00, 1, 32'h203, 0, 32'h80FFFFFF, 0);
    check("sbyte", rdata, 32'hFFFFFF80);
    xact(2'b01, 2'b00, 0, 32'h203, 0, 32'h80FFFFFF, 1);
    check("ubyte", rdata, 32'h00000080);
    xact(2'b00, 2'b01, 0, 32'h302, 32'h1234ABCD, 0, 0);
    xact(2'b01, 2'b10, 0, 32'h404, 0, 32'hCAFEF00D, 5);
    check("wait_word", rdata, 32'hCAFEF00D);
    xact(2'b10, 2'b01, 1, 32'h502, 0, 32'h9ABC1234, 2);
    for (int n = 0; n < 40; n++) begin
      t = 2'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if (t == 2'b11 || sz[1]) a[1:0] = 0;
      else if (sz == 2'b01) a[0] = 0;
      xact(t, sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3));
    end
    @(negedge clk);
    en_mem = 1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h401;
    @(negedge clk);
    check("err_aligned", 32'(aligned_mem), 0);
    check("err_valid", 32'(mem_valid), 0);
    addr = 32'h400; mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("err_sticky", 32'(aligned_mem), 0);
      check("err_novalid", 32'(mem_valid), 0);
      check("err_nodone", 32'(done_mem), 0);
      check("err_nobusy", 32'(busy_mem), 0);
    end
    en_mem = 0; mem_ready = 0; reset = 0;
    @(negedge clk);
    check("err_reset", 32'(aligned_mem), 1);
    reset = 1;
    en_mem = 1; W_R_mem = 2'b01; wordsize_mem = 2'b10; addr = 32'h500;
    @(negedge clk);
    en_mem = 0;
    check("pre_rst_valid", 32'(mem_valid), 1);
    reset = 0;
    @(negedge clk);
    exp_rdata = 0; exp_inst = 0;
    check("mid_rst_valid", 32'(mem_valid), 0);
    check("mid_rst_busy", 32'(busy_mem), 0);
    check("mid_rst_aligned", 32'(aligned_mem), 1);
    check("mid_rst_rdata", rdata, 0);
    reset = 1;
    xact(2'b01, 2'b01, 1, 32'h602, 0, 32'h8001FFFF, 1);
    check("post_rst", rdata, 32'hFFFF8001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
